regfile_bypass_sb: RTL and testbench
====================================

// Module: regfile_bypass_sb
// PURPOSE
//  Parametrised successor register file for the pipelined CPU: NRD combinational read ports, NWR write ports,
//  same-cycle write-to-read bypass, r0 hardwired to zero, and a per-register pending-write scoreboard.
//  The scoreboard is set at issue and cleared at writeback. Sits between decode (reads, issue) and writeback
//  (ALU/mem on port 0, JAL link on port 1), and gives decode the stall information it needs.
// PARAMETERS
//  DW     32  data width in bits
//  NREG   32  number of registers (power of 2, >=2); AW = $clog2(NREG)
//  NRD    2   number of read ports (>=1)
//  NWR    2   number of write ports (>=1); higher index wins on address conflict
// PORTS
//  clk         in   1        clock; all state updates on rising edge
//  rst_n       in   1        asynchronous, active-low reset
//  wr_en       in   NWR      per-port write enable
//  wr_addr     in   NWR*AW   packed write addresses, port k at [k*AW +: AW]
//  wr_data     in   NWR*DW   packed write data, port k at [k*DW +: DW]
//  rd_addr     in   NRD*AW   packed read addresses
//  rd_data     out  NRD*DW   packed read data (combinational)
//  rd_pending  out  NRD      1 = read register has an outstanding producer (combinational)
//  issue_en    in   1        decode issued an instruction that will write issue_addr
//  issue_addr  in   AW       destination of the issued instruction
//  pend_vec    out  NREG     raw scoreboard bits, for debug and hazard unit
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous): all NREG registers clear to 0 and all pending bits clear to 0.
//   With the async reset asserted, rd_data=0 and rd_pending=0 for every port. Writes and issues are ignored.
//  Write: for each register r != 0 at posedge, the new value comes from the highest-index k with
//   wr_en[k] && wr_addr[k]==r. Otherwise the register holds. Writes to r0 are discarded.
//  Read (0 latency): for each port p with a=rd_addr[p]:
//   a==0 -> rd_data=0.
//   a written this cycle by the winning port k -> rd_data=wr_data[k] (bypass).
//   otherwise -> rd_data=mem[a].
//  Scoreboard, per register r != 0, next state at posedge:
//   issue_en && issue_addr==r            -> pend[r]=1; issue has priority over a same-cycle write clear.
//   else any wr_en[k] with wr_addr[k]==r -> pend[r]=0.
//   else                                 -> pend[r] holds.
//   pend[0] is always 0; issue to r0 is ignored.
//  rd_pending[p] = pend[a] && !(a written this cycle) && a!=0. A producer landing this cycle is bypassed, not stalled.
//   An issue in the same cycle does not affect rd_pending until the next cycle.
//  Multiple in-flight producers to one register are not counted: the first writeback clears the bit.
//   Decode must not issue a second writer to a pending register; the block does not check this.
//  Reset mid-operation: it takes effect immediately. The in-flight edge's writes and issues are lost, and no
//   partial update occurs.
//  All arithmetic is width-exact. Addresses >= NREG are impossible since NREG=2**AW.
//  Port 0 with NWR=2 replaces the old RegWrite path, and port 1 replaces the JAL path. JAL now uses its own
//   address and data rather than sharing one port.
// TESTING
//  1 Reset: write r5=0x1234, pulse rst_n low mid-cycle -> r5 reads 0 immediately and pend_vec=0.
//  2 r0: wr_en=01, addr0=0, data=0xFFFF_FFFF; issue r0 -> rd of r0 returns 0, pend_vec[0]=0.
//  3 Conflict: both ports write r31, port0=0xAAAA, port1=0xBBBB -> same-cycle read gives 0xBBBB, and next cycle
//    reads 0xBBBB.
//  4 Bypass: r7=0x10, then write r7=0x20 while reading r7 on both ports -> both read 0x20 in that cycle.
//  5 Scoreboard: issue r3 -> next cycle rd_pending=1. Writeback r3=0x55 -> that cycle rd_pending=0 and
//    rd_data=0x55, and pend[3]=0 after the edge.
//  6 Issue and write r3 in the same cycle -> pend[3]=1 after the edge and mem[3] is updated.

Source files
------------

// File: rtl/regfile_bypass_sb.sv
// ---------------------------------------------------------------------------
// regfile_bypass_sb : multi-port register file with write-to-read bypass,
//                     hardwired r0 and a per-register pending-write scoreboard
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_bypass_sb #(
   parameter int DW   = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2,
   parameter int NWR  = 2,
   localparam int AW  = $clog2(NREG)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NWR-1:0]     wr_en_i,
   input  logic [NWR*AW-1:0]  wr_addr_i,
   input  logic [NWR*DW-1:0]  wr_data_i,
   input  logic [NRD*AW-1:0]  rd_addr_i,
   output logic [NRD*DW-1:0]  rd_data_o,
   output logic [NRD-1:0]     rd_pending_o,
   input  logic               issue_en_i,
   input  logic [AW-1:0]      issue_addr_i,
   output logic [NREG-1:0]    pend_vec_o
);

   logic [NREG-1:0][DW-1:0] mem_q, mem_d;
   logic [NREG-1:0]         pend_q, pend_d;
   logic [NREG-1:0]         w_hit;
   logic [NREG-1:0][DW-1:0] w_wdat;

   // Ascending port scan: a later (higher-index) port overwrites an earlier one.
   always_comb begin
      w_hit  = '0;
      w_wdat = '0;
      for (int k = 0; k < NWR; k++) begin
         if (wr_en_i[k]) begin
            w_hit[wr_addr_i[k*AW +: AW]]  = 1'b1;
            w_wdat[wr_addr_i[k*AW +: AW]] = wr_data_i[k*DW +: DW];
         end
      end
   end

   always_comb begin
      mem_d = mem_q;
      for (int r = 1; r < NREG; r++) begin
         if (w_hit[r]) mem_d[r] = w_wdat[r];
      end
      mem_d[0] = '0;
   end

   // Issue is applied after the writeback clear so it wins on a collision.
   always_comb begin
      pend_d = pend_q & ~w_hit;
      if (issue_en_i) pend_d[issue_addr_i] = 1'b1;
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q  <= '0;
         pend_q <= '0;
      end else begin
         mem_q  <= mem_d;
         pend_q <= pend_d;
      end
   end

   generate
      for (genvar p = 0; p < NRD; p++) begin : g_rd
         logic [AW-1:0] w_a;
         logic          w_zero;
         assign w_a    = rd_addr_i[p*AW +: AW];
         assign w_zero = (w_a == '0);
         // Reset gating keeps the bypass path from leaking write data while rst_n is low.
         assign rd_data_o[p*DW +: DW] = (!rst_n || w_zero) ? '0 :
                                        w_hit[w_a] ? w_wdat[w_a] : mem_q[w_a];
         assign rd_pending_o[p] = rst_n && !w_zero && pend_q[w_a] && !w_hit[w_a];
      end
   endgenerate

   assign pend_vec_o = pend_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_bypass_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_bypass_sb : directed self-checking bench for regfile_bypass_sb
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_regfile_bypass_sb;

   localparam int DW = 32, NREG = 32, NRD = 2, NWR = 2, AW = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NWR-1:0]    wr_en;
   logic [NWR*AW-1:0] wr_addr;
   logic [NWR*DW-1:0] wr_data;
   logic [NRD*AW-1:0] rd_addr;
   logic [NRD*DW-1:0] rd_data;
   logic [NRD-1:0]    rd_pending;
   logic              issue_en;
   logic [AW-1:0]     issue_addr;
   logic [NREG-1:0]   pend_vec;

   int n_checks = 0;
   int n_errors = 0;

   regfile_bypass_sb #(.DW(DW), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en_i      (wr_en),
      .wr_addr_i    (wr_addr),
      .wr_data_i    (wr_data),
      .rd_addr_i    (rd_addr),
      .rd_data_o    (rd_data),
      .rd_pending_o (rd_pending),
      .issue_en_i   (issue_en),
      .issue_addr_i (issue_addr),
      .pend_vec_o   (pend_vec)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [31:0] d1,
                        input logic [4:0] r0, input logic [4:0] r1,
                        input logic ie, input logic [4:0] ia);
      wr_en      = en;
      wr_addr    = {a1, a0};
      wr_data    = {d1, d0};
      rd_addr    = {r1, r0};
      issue_en   = ie;
      issue_addr = ia;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(2'b01, 5'd5, 32'h1234, 5'd0, 32'h0, 5'd5, 5'd0, 1'b1, 5'd5);
      chk("reset_rd_bypass_gated", {32'h0, rd_data[31:0]}, 64'h0);
      chk("reset_pend_vec", {32'h0, pend_vec}, 64'h0);
      @(posedge clk); #1;
      chk("reset_ignores_write", {32'h0, rd_data[31:0]}, 64'h0);
      rst_n = 1'b1;

      // Test 1: write r5, issue r9, then asynchronous reset mid-cycle
      drive(2'b01, 5'd5, 32'h1234, 5'd0, 32'h0, 5'd5, 5'd9, 1'b1, 5'd9);
      step();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd9, 1'b0, 5'd0);
      chk("r5_written", {32'h0, rd_data[31:0]}, 64'h1234);
      chk("pend_r9_set", {32'h0, pend_vec}, 64'h200);
      chk("rd_pending_r9_port1", {62'h0, rd_pending}, 64'h2);
      rst_n = 1'b0;
      #1;
      chk("async_reset_r5", {32'h0, rd_data[31:0]}, 64'h0);
      chk("async_reset_pend", {32'h0, pend_vec}, 64'h0);
      rst_n = 1'b1;
      step();
      chk("r5_after_reset", {32'h0, rd_data[31:0]}, 64'h0);

      // Test 2: r0 write and issue are discarded
      drive(2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd0);
      chk("r0_same_cycle", {32'h0, rd_data[31:0]}, 64'h0);
      step();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
      chk("r0_after_edge", {32'h0, rd_data[31:0]}, 64'h0);
      chk("r0_pend_vec", {32'h0, pend_vec}, 64'h0);

      // Test 3: both ports write r31, port 1 wins
      drive(2'b11, 5'd31, 32'hAAAA, 5'd31, 32'hBBBB, 5'd31, 5'd31, 1'b0, 5'd0);
      chk("conflict_bypass_p0", {32'h0, rd_data[31:0]}, 64'hBBBB);
      chk("conflict_bypass_p1", {32'h0, rd_data[63:32]}, 64'hBBBB);
      step();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd31, 5'd0, 1'b0, 5'd0);
      chk("conflict_stored", {32'h0, rd_data[31:0]}, 64'hBBBB);

      // Test 4: bypass of r7 on both read ports
      drive(2'b01, 5'd7, 32'h10, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0);
      step();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0);
      chk("r7_old", {32'h0, rd_data[31:0]}, 64'h10);
      drive(2'b10, 5'd0, 32'h0, 5'd7, 32'h20, 5'd7, 5'd7, 1'b0, 5'd0);
      chk("bypass_p0", {32'h0, rd_data[31:0]}, 64'h20);
      chk("bypass_p1", {32'h0, rd_data[63:32]}, 64'h20);
      step();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd31, 1'b0, 5'd0);
      chk("r7_new_p0", {32'h0, rd_data[31:0]}, 64'h20);
      chk("r31_p1", {32'h0, rd_data[63:32]}, 64'hBBBB);

      // Test 5: scoreboard set by issue, cleared by writeback
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd7, 1'b1, 5'd3);
      chk("issue_not_visible_yet", {62'h0, rd_pending}, 64'h0);
      step();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd7, 1'b0, 5'd0);
      chk("pending_after_issue", {62'h0, rd_pending}, 64'h1);
      chk("pend_vec_r3", {32'h0, pend_vec}, 64'h8);
      drive(2'b01, 5'd3, 32'h55, 5'd0, 32'h0, 5'd3, 5'd7, 1'b0, 5'd0);
      chk("wb_pending_cleared", {62'h0, rd_pending}, 64'h0);
      chk("wb_bypass_data", {32'h0, rd_data[31:0]}, 64'h55);
      step();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b0, 5'd0);
      chk("pend_vec_cleared", {32'h0, pend_vec}, 64'h0);
      chk("r3_stored", {32'h0, rd_data[63:32]}, 64'h55);

      // Test 6: issue and write r3 together, issue wins the scoreboard
      drive(2'b10, 5'd0, 32'h0, 5'd3, 32'h66, 5'd3, 5'd3, 1'b1, 5'd3);
      step();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b0, 5'd0);
      chk("issue_beats_clear", {32'h0, pend_vec}, 64'h8);
      chk("r3_updated", {32'h0, rd_data[31:0]}, 64'h66);
      chk("r3_pending_both", {62'h0, rd_pending}, 64'h3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
